// File: rtl/keyboard_pkg.sv
// Shared types and constants for the keyboard voice allocation path.
package keyboard_pkg;

    localparam int unsigned NKEYS_MAX = 32;
    localparam int unsigned KEY_W     = 5;
    localparam int unsigned AGE_W     = 3;
    localparam int unsigned AGE_MAX   = 7;

    typedef logic [KEY_W-1:0] key_idx_t;
    typedef logic [AGE_W-1:0] age_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } alloc_state_t;

endpackage

// File: rtl/voice_picker.sv
// Combinational voice selection: lowest free voice and, with VOICE_STEAL_EN, the oldest voice.
module voice_picker
    import keyboard_pkg::*;
#(
    parameter int unsigned NVOICES = 4,
    localparam int unsigned VIDX_W = $clog2(NVOICES)
) (
    input  logic [NVOICES-1:0]  voice_on,
`ifdef VOICE_STEAL_EN
    input  age_t [NVOICES-1:0]  age,
    output logic [VIDX_W-1:0]   oldest_idx_c,
`endif
    output logic [VIDX_W-1:0]   free_idx_c,
    output logic                free_found_c
);

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        free_idx_c   = '0;
        free_found_c = 1'b0;
        for (int v = int'(NVOICES) - 1; v >= 0; v--) begin
            if (!voice_on[v]) begin
                free_idx_c   = VIDX_W'(v);
                free_found_c = 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Strict comparison keeps ties on the lowest index.
    always_comb begin
        age_t best;
        best         = age[0];
        oldest_idx_c = '0;
        for (int v = 1; v < int'(NVOICES); v++) begin
            if (age[v] > best) begin
                best         = age[v];
                oldest_idx_c = VIDX_W'(v);
            end
        end
    end
`endif

endmodule

// File: rtl/voice_allocator.sv
// Maps key-state frames onto a fixed pool of voices, one key per cycle.
// Optional feature: define VOICE_STEAL_EN to steal the oldest voice when none is free.
module voice_allocator
    import keyboard_pkg::*;
#(
    parameter int unsigned NVOICES = 4,
    parameter int unsigned NKEYS   = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_valid,
    input  logic [NKEYS_MAX-1:0]        frame,
    output logic                        busy,
    output logic [NVOICES-1:0]          voice_on,
    output key_idx_t [NVOICES-1:0]      voice_key,
    output logic [NVOICES-1:0]          voice_start,
    output logic [7:0]                  drop_count
);

    localparam int unsigned VIDX_W = $clog2(NVOICES);

    alloc_state_t           state_q, state_d;
    key_idx_t               k_q, k_d;
    logic [NKEYS_MAX-1:0]   cur_keys_q, cur_keys_d;
    logic [NKEYS_MAX-1:0]   prev_keys_q, prev_keys_d;
    logic [NKEYS_MAX-1:0]   pend_frame_q, pend_frame_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   busy_q, busy_d;
    logic [NVOICES-1:0]     voice_on_q, voice_on_d;
    key_idx_t [NVOICES-1:0] voice_key_q, voice_key_d;
    logic [NVOICES-1:0]     voice_start_q, voice_start_d;
    logic [7:0]             drop_count_q, drop_count_d;

    logic [VIDX_W-1:0]      free_idx_c;
    logic                   free_found_c;
    logic [VIDX_W-1:0]      tgt_c;
    logic                   assign_en_c;

`ifdef VOICE_STEAL_EN
    age_t [NVOICES-1:0]     age_q, age_d;
    logic [VIDX_W-1:0]      oldest_idx_c;
`endif

    voice_picker #(.NVOICES(NVOICES)) u_picker (
        .voice_on     (voice_on_q),
`ifdef VOICE_STEAL_EN
        .age          (age_q),
        .oldest_idx_c (oldest_idx_c),
`endif
        .free_idx_c   (free_idx_c),
        .free_found_c (free_found_c)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cur_keys_d    = cur_keys_q;
        prev_keys_d   = prev_keys_q;
        pend_frame_d  = pend_frame_q;
        pend_valid_d  = pend_valid_q;
        voice_on_d    = voice_on_q;
        voice_key_d   = voice_key_q;
        voice_start_d = '0;
        drop_count_d  = drop_count_q;
        assign_en_c   = 1'b0;
        tgt_c         = '0;
`ifdef VOICE_STEAL_EN
        age_d         = age_q;
`endif

        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    state_d    = SCAN;
                    k_d        = '0;
                    cur_keys_d = frame;
                end else if (pend_valid_q) begin
                    state_d      = SCAN;
                    k_d          = '0;
                    cur_keys_d   = pend_frame_q;
                    pend_valid_d = 1'b0;
                end
            end

            SCAN: begin
                if (frame_valid) begin
                    pend_valid_d = 1'b1;
                    pend_frame_d = frame;
                end
                k_d = k_q + KEY_W'(1);
                if (k_q == KEY_W'(NKEYS - 1)) begin
                    state_d = COMMIT;
                end

                if (prev_keys_q[k_q] && !cur_keys_q[k_q]) begin
                    for (int v = 0; v < int'(NVOICES); v++) begin
                        if (voice_on_q[v] && voice_key_q[v] == k_q) begin
                            voice_on_d[v] = 1'b0;
                        end
                    end
                end else if (!prev_keys_q[k_q] && cur_keys_q[k_q]) begin
`ifdef VOICE_STEAL_EN
                    assign_en_c = 1'b1;
                    tgt_c       = free_found_c ? free_idx_c : oldest_idx_c;
`else
                    if (free_found_c) begin
                        assign_en_c = 1'b1;
                        tgt_c       = free_idx_c;
                    end else if (drop_count_q != 8'hFF) begin
                        drop_count_d = drop_count_q + 8'd1;
                    end
`endif
                end
            end

            COMMIT: begin
                prev_keys_d  = cur_keys_q;
                pend_valid_d = 1'b0;
                // A frame arriving now supersedes any pending one and starts back-to-back.
                if (frame_valid) begin
                    state_d    = SCAN;
                    k_d        = '0;
                    cur_keys_d = frame;
                end else if (pend_valid_q) begin
                    state_d    = SCAN;
                    k_d        = '0;
                    cur_keys_d = pend_frame_q;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (assign_en_c) begin
            for (int v = 0; v < int'(NVOICES); v++) begin
                if (VIDX_W'(v) == tgt_c) begin
                    voice_on_d[v]    = 1'b1;
                    voice_key_d[v]   = k_q;
                    voice_start_d[v] = 1'b1;
`ifdef VOICE_STEAL_EN
                    age_d[v]         = '0;
                end else if (voice_on_q[v] && age_q[v] != AGE_W'(AGE_MAX)) begin
                    age_d[v]         = age_q[v] + AGE_W'(1);
`endif
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            cur_keys_q    <= '0;
            prev_keys_q   <= '0;
            pend_frame_q  <= '0;
            pend_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            voice_on_q    <= '0;
            voice_key_q   <= '0;
            voice_start_q <= '0;
            drop_count_q  <= '0;
`ifdef VOICE_STEAL_EN
            age_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cur_keys_q    <= cur_keys_d;
            prev_keys_q   <= prev_keys_d;
            pend_frame_q  <= pend_frame_d;
            pend_valid_q  <= pend_valid_d;
            busy_q        <= busy_d;
            voice_on_q    <= voice_on_d;
            voice_key_q   <= voice_key_d;
            voice_start_q <= voice_start_d;
            drop_count_q  <= drop_count_d;
`ifdef VOICE_STEAL_EN
            age_q         <= age_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign voice_on    = voice_on_q;
    assign voice_key   = voice_key_q;
    assign voice_start = voice_start_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: expected start pulses and end-of-scan states are queued by stimulus.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NK = 24;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame_valid;
    logic [31:0]        frame;
    logic               busy;
    logic [NV-1:0]      voice_on;
    logic [NV-1:0][4:0] voice_key;
    logic [NV-1:0]      voice_start;
    logic [7:0]         drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int voice;
        int key;
        int offset;
    } pulse_t;

    typedef struct {
        int                 len;
        int                 on;
        logic [NV-1:0][4:0] keys;
        int                 drop;
    } epi_t;

    pulse_t pq[$];
    epi_t   eq[$];

    always #5 clk = ~clk;

    voice_allocator #(.NVOICES(NV), .NKEYS(NK)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame       (frame),
        .busy        (busy),
        .voice_on    (voice_on),
        .voice_key   (voice_key),
        .voice_start (voice_start),
        .drop_count  (drop_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_pulse(input int v, input int k, input int off);
        pulse_t p;
        p.voice = v; p.key = k; p.offset = off;
        pq.push_back(p);
    endtask

    task automatic exp_epi(input int len, input int on, input int k0, input int k1,
                           input int k2, input int k3, input int drop);
        epi_t e;
        e.len = len; e.on = on; e.drop = drop;
        e.keys[0] = 5'(k0); e.keys[1] = 5'(k1); e.keys[2] = 5'(k2); e.keys[3] = 5'(k3);
        eq.push_back(e);
    endtask

    // Monitor: pops expectations whenever a start pulse appears or a busy episode ends.
    int cyc = 0;
    int rise_cyc = 0;
    int busy_len = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        pulse_t p;
        epi_t   e;
        cyc++;
        if (busy && !busy_prev) begin
            rise_cyc = cyc;
            busy_len = 0;
        end
        if (busy) busy_len++;
        for (int v = 0; v < NV; v++) begin
            if (voice_start[v]) begin
                if (pq.size() == 0) begin
                    check("start_unexpected_qsize", pq.size(), 1);
                end else begin
                    p = pq.pop_front();
                    check("start_voice", v, p.voice);
                    check("start_key", int'(voice_key[v]), p.key);
                    check("start_offset", cyc - rise_cyc, p.offset);
                end
            end
        end
        if (!busy && busy_prev) begin
            if (eq.size() == 0) begin
                check("episode_unexpected_qsize", eq.size(), 1);
            end else begin
                e = eq.pop_front();
                check("busy_len", busy_len, e.len);
                check("voice_on", int'(voice_on), e.on);
                check("drop_count", int'(drop_count), e.drop);
                for (int v = 0; v < NV; v++) begin
                    if (e.on[v]) check("voice_key", int'(voice_key[v]), int'(e.keys[v]));
                end
            end
        end
        busy_prev = busy;
    end

    task automatic pulse_fv(input logic [31:0] f);
        frame       = f;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        @(negedge clk);
        pulse_fv(f);
    endtask

    task automatic wait_done();
        int t = 0;
        while (busy !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("busy_timeout", int'(t < 300), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int idle_busy;
        reset       = 1'b1;
        frame_valid = 1'b0;
        frame       = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_voice_on", int'(voice_on), 0);
        check("rst_voice_key", int'(voice_key), 0);
        check("rst_voice_start", int'(voice_start), 0);
        check("rst_drop", int'(drop_count), 0);
        reset = 1'b0;

        // Two presses land on voices 0 and 1, pulses two cycles apart.
        exp_pulse(0, 0, 1);
        exp_pulse(1, 2, 3);
        exp_epi(25, 'h3, 0, 2, 0, 0, 0);
        send_frame(32'h000005);
        wait_done();

        // Release of key 0 only.
        exp_epi(25, 'h2, 0, 2, 0, 0, 0);
        send_frame(32'h000004);
        wait_done();

        // Five keys into four voices.
        do_reset();
        for (int i = 0; i < 4; i++) exp_pulse(i, i, i + 1);
`ifdef VOICE_STEAL_EN
        exp_pulse(0, 4, 5);
        exp_epi(25, 'hF, 4, 1, 2, 3, 0);
`else
        exp_epi(25, 'hF, 0, 1, 2, 3, 1);
`endif
        send_frame(32'h00001F);
        wait_done();

        // Latest pending frame wins.
        do_reset();
        exp_pulse(0, 2, 28);
        exp_epi(50, 'h1, 2, 0, 0, 0, 0);
        send_frame(32'h000000);
        repeat (2) @(negedge clk);
        pulse_fv(32'h000001);
        repeat (3) @(negedge clk);
        pulse_fv(32'h000002);
        repeat (3) @(negedge clk);
        pulse_fv(32'h000004);
        wait_done();

        // Reset mid-scan discards state and the pending frame.
        do_reset();
        for (int i = 0; i < 4; i++) exp_pulse(i, i, i + 1);
        exp_epi(10, 0, 0, 0, 0, 0, 0);
        send_frame(32'hFFFFFF);
        repeat (3) @(negedge clk);
        pulse_fv(32'h000003);
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_voice_key", int'(voice_key), 0);
        check("midrst_voice_start", int'(voice_start), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        idle_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        check("no_pending_run", idle_busy, 0);

`ifndef VOICE_STEAL_EN
        // 20 drops per full frame; saturates after 13 frames.
        do_reset();
        for (int i = 0; i < 4; i++) exp_pulse(i, i, i + 1);
        for (int i = 1; i <= 15; i++) begin
            d = (20 * i > 255) ? 255 : 20 * i;
            exp_epi(25, 'hF, 0, 1, 2, 3, d);
            send_frame(32'hFFFFFF);
            wait_done();
            exp_epi(25, 'hF, 0, 1, 2, 3, d);
            send_frame(32'h00000F);
            wait_done();
        end
        check("drop_saturated", int'(drop_count), 255);
`endif

        repeat (3) @(negedge clk);
        check("pulse_queue_left", pq.size(), 0);
        check("episode_queue_left", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
